store_uart_tracer: RTL

STORE_UART_TRACER -- requirements
Module: store_uart_tracer

---
 rtl/store_uart_tracer.sv | 84 ++++++++
 1 files changed

// File: rtl/store_uart_tracer.sv
// store_uart_tracer: FIFO-captures CPU stores {dataadr,writedata} and streams each as a 9-byte (A5 sync + addr + data) 8N1 frame on tx; reports busy, fifo_count, sticky overflow, saturating drop_count
module store_uart_tracer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                memwrite,
  input  logic [31:0]         dataadr,
  input  logic [31:0]         writedata,
  output logic                tx,
  output logic                busy,
  output logic [DEPTH_LOG2:0] fifo_count,
  output logic                overflow,
  output logic [7:0]          drop_count
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [DEPTH_LOG2:0] full = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2);
  localparam logic [15:0] last = 16'(CLKS_PER_BIT - 1);
  state_t state;
  logic [63:0] mem [2 ** DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wp, rp;
  logic [63:0] frame;
  logic [3:0] byte_idx;
  logic [2:0] bit_idx;
  logic [15:0] baud;
  logic pop, push, drop, tick;
  logic [7:0] cur_byte;
  always_comb begin
    pop = state == IDLE && fifo_count != '0;
    push = memwrite && (fifo_count != full || pop);
    drop = memwrite && !push;
    tick = baud == last;
    cur_byte = byte_idx == '0 ? 8'hA5 : frame[63:56];
  end
  always_ff @(posedge clk) if (push) mem[wp] <= {dataadr, writedata};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (push != pop) fifo_count <= push ? fifo_count + 1'b1 : fifo_count - 1'b1;
      if (drop) overflow <= 1'b1;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      busy <= 1'b0;
      baud <= '0;
      byte_idx <= '0;
      bit_idx <= '0;
      frame <= '0;
    end else begin
      tx <= state == START ? 1'b0 : state == DATA ? cur_byte[bit_idx] : 1'b1;
      busy <= state != IDLE;
      baud <= (state == IDLE || tick) ? '0 : baud + 1'b1;
      case (state)
        IDLE: if (pop) begin
          frame <= mem[rp];
          byte_idx <= '0;
          bit_idx <= '0;
          state <= START;
        end
        START: if (tick) state <= DATA;
        DATA: if (tick) begin
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) state <= STOP;
        end
        STOP: if (tick) begin
          if (byte_idx != '0) frame <= {frame[55:0], 8'h00};
          byte_idx <= byte_idx + 1'b1;
          state <= byte_idx == 4'd8 ? IDLE : START;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
